// File: rtl/oflow_mem_buffer.sv
// oflow_mem_buffer
//   Two-port feature-history memory for the oflow tracking pipeline. Records
//   are addressed by (frame_num mod H, offset). There are up to two writes per
//   clock and two combinational reads.
//
//   Optional feature (compile-time macro OFLOW_MEM_TAG_CHECK_EN):
//     defined   - each entry also keeps a frame tag and a valid bit. A read hits
//                 only when the entry is valid and its tag equals frame_num.
//                 A miss reads all zeros.
//     undefined - there are no tags or valid bits. Reads return the raw slot
//                 contents.
//
// Ports
//   clk                    in   rising-edge clock
//   reset_N                in   synchronous, active-high reset. It clears the
//                               valid bits, blocks writes and forces both read
//                               outputs to zero.
//   frame_num              in   frame addressed by the write and read ports
//   num_of_history_frames  in   active history depth H (a value of 0 acts as 1)
//   data_in_0/1            in   write data for port 0 and port 1
//   offset_0/1             in   entry offset, shared by write and read
//   we                     in   write enable for both ports
//   data_out_0/1           out  read data at (frame_num, offset_0/1)
module oflow_mem_buffer #(
   parameter int DATA_WIDTH                  = 284,
   parameter int OFFSET_WIDTH                = 6,
   parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
   parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3
) (
   input  logic                                   clk,
   input  logic                                   reset_N,
   input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
   input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
   input  logic [DATA_WIDTH-1:0]                  data_in_0,
   input  logic [DATA_WIDTH-1:0]                  data_in_1,
   input  logic [OFFSET_WIDTH-1:0]                offset_0,
   input  logic [OFFSET_WIDTH-1:0]                offset_1,
   input  logic                                   we,
   output logic [DATA_WIDTH-1:0]                  data_out_0,
   output logic [DATA_WIDTH-1:0]                  data_out_1
);

   localparam int HW    = NUM_OF_HISTORY_FRAMES_WIDTH;
   localparam int FW    = TOTAL_FRAME_NUM_WIDTH;
   localparam int AW    = HW + OFFSET_WIDTH;
   localparam int DEPTH = 1 << AW;

   // Restoring remainder: frame_num mod h, one dividend bit at a time.
   // Before each shift rem < h holds, so 2*rem+1 < 2^(HW+1) and the extra
   // bit is enough headroom.
   function automatic logic [HW-1:0] frame_mod(input logic [FW-1:0] f,
                                                input logic [HW-1:0] h);
      logic [HW:0] rem;
      rem = '0;
      for (int i = FW - 1; i >= 0; i--) begin
         rem = {rem[HW-1:0], f[i]};
         if (rem >= {1'b0, h})
            rem = rem - {1'b0, h};
      end
      return rem[HW-1:0];
   endfunction

   logic [HW-1:0] h_eff;
   logic [HW-1:0] slot;
   logic [AW-1:0] addr_0;
   logic [AW-1:0] addr_1;
   logic          hit_0;
   logic          hit_1;

   assign h_eff  = (num_of_history_frames == '0) ? HW'(1) : num_of_history_frames;
   assign slot   = frame_mod(frame_num, h_eff);
   assign addr_0 = {slot, offset_0};
   assign addr_1 = {slot, offset_1};

   // The data array is never reset. Port 1 is written last, so port 1 wins
   // when both ports target the same offset.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef OFLOW_MEM_TAG_CHECK_EN
   logic [FW-1:0]    tag [DEPTH];
   logic [DEPTH-1:0] valid;

   always_ff @(posedge clk) begin
      if (!reset_N && we) begin
         mem[addr_0] <= data_in_0;
         tag[addr_0] <= frame_num;
         mem[addr_1] <= data_in_1;
         tag[addr_1] <= frame_num;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_N)
         valid <= '0;
      else if (we) begin
         valid[addr_0] <= 1'b1;
         valid[addr_1] <= 1'b1;
      end
   end

   // When a slot is reused by a newer frame (or H is changed), the old
   // entries still hold their earlier tag. The tag compare makes them miss.
   assign hit_0 = valid[addr_0] && (tag[addr_0] == frame_num);
   assign hit_1 = valid[addr_1] && (tag[addr_1] == frame_num);
`else
   always_ff @(posedge clk) begin
      if (!reset_N && we) begin
         mem[addr_0] <= data_in_0;
         mem[addr_1] <= data_in_1;
      end
   end

   assign hit_0 = 1'b1;
   assign hit_1 = 1'b1;
`endif

   // Reads are combinational. A read of an entry that is written this cycle
   // returns its contents from before the write until the clock edge.
   always_comb begin
      data_out_0 = '0;
      data_out_1 = '0;
      if (!reset_N) begin
         if (hit_0) data_out_0 = mem[addr_0];
         if (hit_1) data_out_1 = mem[addr_1];
      end
   end

endmodule

// File: tb/tb_oflow_mem_buffer.sv
// tb_oflow_mem_buffer
//   Self-checking bench for oflow_mem_buffer. A behavioural model keeps the
//   last record written to each (slot, offset). Expected reads come from the
//   slot rule frame mod max(H,1) and from the tag/valid hit rule. When
//   OFLOW_MEM_TAG_CHECK_EN is defined, the model also tracks frame tags and
//   valid bits. When it is undefined, entries that were never written are not
//   compared, because their value is unknown.
module tb_oflow_mem_buffer;

   localparam int DW  = 284;
   localparam int OW  = 6;
   localparam int FW  = 8;
   localparam int HW  = 3;
   localparam int NS  = 1 << HW;
   localparam int NO  = 1 << OW;

   logic          clk = 1'b0;
   logic          reset_N;
   logic [FW-1:0] frame_num;
   logic [HW-1:0] num_of_history_frames;
   logic [DW-1:0] data_in_0, data_in_1;
   logic [OW-1:0] offset_0, offset_1;
   logic          we;
   logic [DW-1:0] data_out_0, data_out_1;

   int checks   = 0;
   int failures = 0;

   oflow_mem_buffer dut (
      .clk                   (clk),
      .reset_N               (reset_N),
      .frame_num             (frame_num),
      .num_of_history_frames (num_of_history_frames),
      .data_in_0             (data_in_0),
      .data_in_1             (data_in_1),
      .offset_0              (offset_0),
      .offset_1              (offset_1),
      .we                    (we),
      .data_out_0            (data_out_0),
      .data_out_1            (data_out_1)
   );

   always #5 clk = ~clk;

   // Reference model: the most recent write to each physical entry.
   logic [DW-1:0] m_data  [NS][NO];
   int            m_tag   [NS][NO];
   bit            m_valid [NS][NO];
   bit            m_wr    [NS][NO];

   function automatic int heff(input int h);
      return (h == 0) ? 1 : h;
   endfunction

   function automatic logic [DW-1:0] rand_rec();
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < (DW + 31) / 32; i++)
         r = (r << 32) | DW'($urandom);
      return r;
   endfunction

   // Expected read value at the current inputs. known=0 means the value is
   // undefined, which happens only for never-written entries in a build
   // without tag checking.
   function automatic logic [DW-1:0] exp_rd(input int o, output bit known);
      int s;
      s = int'(frame_num) % heff(int'(num_of_history_frames));
      known = 1'b1;
      if (reset_N) return '0;
`ifdef OFLOW_MEM_TAG_CHECK_EN
      if (m_valid[s][o] && m_tag[s][o] == int'(frame_num)) return m_data[s][o];
      return '0;
`else
      known = m_wr[s][o];
      return m_data[s][o];
`endif
   endfunction

   // Drive we/reset for one edge, update the model as the spec dictates, and
   // return to idle (we=0, reset inactive) 1 ns after the edge.
   task automatic step(input bit w, input bit rst);
      int s;
      we = w;
      reset_N = rst;
      @(posedge clk);
      s = int'(frame_num) % heff(int'(num_of_history_frames));
      if (rst) begin
         for (int i = 0; i < NS; i++)
            for (int j = 0; j < NO; j++) m_valid[i][j] = 1'b0;
      end else if (w) begin
         m_data[s][offset_0] = data_in_0; m_tag[s][offset_0] = int'(frame_num);
         m_valid[s][offset_0] = 1'b1;     m_wr[s][offset_0] = 1'b1;
         m_data[s][offset_1] = data_in_1; m_tag[s][offset_1] = int'(frame_num);
         m_valid[s][offset_1] = 1'b1;     m_wr[s][offset_1] = 1'b1;
      end
      #1;
      we = 1'b0;
      reset_N = 1'b0;
      #1;
   endtask

   task automatic set_rd(input int h, input int f, input int o0, input int o1);
      num_of_history_frames = HW'(h);
      frame_num = FW'(f);
      offset_0 = OW'(o0);
      offset_1 = OW'(o1);
      #1;
   endtask

   task automatic test_reset();
      set_rd(5, 6, 34, 35);
      we = 1'b0;
      reset_N = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < NO; j++) begin
            m_valid[i][j] = 1'b0; m_wr[i][j] = 1'b0;
         end
      checks += 2;
      if (data_out_0 !== '0) begin failures++; $display("FAIL reset_p0 got=%h exp=0", data_out_0); end
      if (data_out_1 !== '0) begin failures++; $display("FAIL reset_p1 got=%h exp=0", data_out_1); end
      reset_N = 1'b0;
      #1;
   endtask

   task automatic test_basic_write();
      logic [DW-1:0] a, b, e0, e1;
      bit k0, k1;
      a = rand_rec(); b = rand_rec();
      set_rd(5, 6, 34, 35);
      data_in_0 = a; data_in_1 = b; we = 1'b1;
      #1;
      // Before the edge the entries still hold their old contents.
      e0 = exp_rd(34, k0); e1 = exp_rd(35, k1);
      if (k0) begin checks++; if (data_out_0 !== e0) begin failures++; $display("FAIL basic_pre_p0 got=%h exp=%h", data_out_0, e0); end end
      if (k1) begin checks++; if (data_out_1 !== e1) begin failures++; $display("FAIL basic_pre_p1 got=%h exp=%h", data_out_1, e1); end end
      step(1'b1, 1'b0);
      checks += 2;
      if (data_out_0 !== a) begin failures++; $display("FAIL basic_p0 got=%h exp=%h", data_out_0, a); end
      if (data_out_1 !== b) begin failures++; $display("FAIL basic_p1 got=%h exp=%h", data_out_1, b); end
   endtask

   task automatic test_same_offset();
      logic [DW-1:0] x2;
      set_rd(5, 3, 10, 10);
      data_in_0 = rand_rec(); x2 = rand_rec(); data_in_1 = x2;
      step(1'b1, 1'b0);
      checks += 2;
      if (data_out_0 !== x2) begin failures++; $display("FAIL same_off_p0 got=%h exp=%h", data_out_0, x2); end
      if (data_out_1 !== x2) begin failures++; $display("FAIL same_off_p1 got=%h exp=%h", data_out_1, x2); end
   endtask

   task automatic test_slot_alias();
      logic [DW-1:0] c, d, e0, e1;
      bit k0, k1;
      c = rand_rec(); d = rand_rec();
      set_rd(5, 1, 0, 0); data_in_0 = c; data_in_1 = c; step(1'b1, 1'b0);
      set_rd(5, 6, 1, 1); data_in_0 = d; data_in_1 = d; step(1'b1, 1'b0);
      set_rd(5, 6, 0, 1);
      e0 = exp_rd(0, k0); e1 = exp_rd(1, k1);
      if (k0) begin checks++; if (data_out_0 !== e0) begin failures++; $display("FAIL alias_f6_o0 got=%h exp=%h", data_out_0, e0); end end
      checks++;
      if (data_out_1 !== d) begin failures++; $display("FAIL alias_f6_o1 got=%h exp=%h", data_out_1, d); end
      set_rd(5, 1, 0, 1);
      e0 = exp_rd(0, k0); e1 = exp_rd(1, k1);
      if (k0) begin checks++; if (data_out_0 !== e0) begin failures++; $display("FAIL alias_f1_o0 got=%h exp=%h", data_out_0, e0); end end
      if (k1) begin checks++; if (data_out_1 !== e1) begin failures++; $display("FAIL alias_f1_o1 got=%h exp=%h", data_out_1, e1); end end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] e, f, e1;
      bit k1;
      e = rand_rec(); f = rand_rec();
      set_rd(5, 255, 5, 5); data_in_0 = e; data_in_1 = e; step(1'b1, 1'b0);
      set_rd(5, 0, 5, 5);   data_in_0 = f; data_in_1 = f; step(1'b1, 1'b0);
      checks++;
      if (data_out_0 !== f) begin failures++; $display("FAIL wrap_f0 got=%h exp=%h", data_out_0, f); end
      set_rd(5, 255, 5, 5);
      e1 = exp_rd(5, k1);
      if (k1) begin checks++; if (data_out_1 !== e1) begin failures++; $display("FAIL wrap_f255 got=%h exp=%h", data_out_1, e1); end end
   endtask

   task automatic test_reset_clears();
      logic [DW-1:0] e0, e1;
      bit k0, k1;
      int fr [3] = '{6, 3, 0};
      int o0 [3] = '{34, 10, 5};
      int o1 [3] = '{35, 10, 5};
      set_rd(5, 6, 34, 35);
      data_in_0 = rand_rec(); data_in_1 = rand_rec();
      reset_N = 1'b1; we = 1'b1;
      #1;
      checks += 2;
      if (data_out_0 !== '0) begin failures++; $display("FAIL rst_live_p0 got=%h exp=0", data_out_0); end
      if (data_out_1 !== '0) begin failures++; $display("FAIL rst_live_p1 got=%h exp=0", data_out_1); end
      step(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         set_rd(5, fr[i], o0[i], o1[i]);
         e0 = exp_rd(o0[i], k0); e1 = exp_rd(o1[i], k1);
         if (k0) begin checks++; if (data_out_0 !== e0) begin failures++; $display("FAIL rst_clear_p0 f=%0d got=%h exp=%h", fr[i], data_out_0, e0); end end
         if (k1) begin checks++; if (data_out_1 !== e1) begin failures++; $display("FAIL rst_clear_p1 f=%0d got=%h exp=%h", fr[i], data_out_1, e1); end end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] e0, e1;
      bit k0, k1, w, r;
      int base;
      base = 0;
      for (int it = 0; it < 600; it++) begin
         if (it % 100 == 0) base = int'($urandom_range(0, 255));
         num_of_history_frames = HW'($urandom_range(0, 7));
         frame_num = FW'(base + int'($urandom_range(0, 9)));
         offset_0 = OW'($urandom_range(0, 7));
         offset_1 = OW'($urandom_range(0, 7));
         data_in_0 = rand_rec(); data_in_1 = rand_rec();
         w = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 39) == 0);
         we = w; reset_N = r;
         #1;
         e0 = exp_rd(int'(offset_0), k0); e1 = exp_rd(int'(offset_1), k1);
         if (k0) begin checks++; if (data_out_0 !== e0) begin failures++; $display("FAIL rand_p0 it=%0d got=%h exp=%h", it, data_out_0, e0); end end
         if (k1) begin checks++; if (data_out_1 !== e1) begin failures++; $display("FAIL rand_p1 it=%0d got=%h exp=%h", it, data_out_1, e1); end end
         step(w, r);
      end
   endtask

   initial begin
      reset_N = 1'b1; we = 1'b0; frame_num = '0; num_of_history_frames = '0;
      data_in_0 = '0; data_in_1 = '0; offset_0 = '0; offset_1 = '0;
      @(negedge clk);
      test_reset();
      test_basic_write();
      test_same_offset();
      test_slot_alias();
      test_wrap();
      test_reset_clears();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
